// File: rtl/comparador_pkg.sv
// -----------------------------------------------------------------------------
// comparador_pkg
// Shared definitions for the serial magnitude comparator:
//   - state_t   : controller states (IDLE, CMP)
//   - RES_*     : {lt, eq, gt} result encodings
//   - ndig()    : number of DIGIT-bit slices in a WIDTH-bit operand
// -----------------------------------------------------------------------------
package comparador_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    // Result vector ordering is {lt, eq, gt}
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_LT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_GT   = 3'b001;

    function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/comparador_serial_if.sv
// -----------------------------------------------------------------------------
// comparador_serial_if
// Start/done handshake bundle of the serial comparator.
//   master: drives start, con_signo, a, b; observes ready, done, lt, eq, gt, pasos
//   slave : the comparator side (opposite directions)
// -----------------------------------------------------------------------------
interface comparador_serial_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
);
    import comparador_pkg::*;

    localparam int unsigned NDIG = ndig(WIDTH, DIGIT);
    localparam int unsigned PW   = $clog2(NDIG + 1);

    logic             start;
    logic             con_signo;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic             lt;
    logic             eq;
    logic             gt;
    logic [PW-1:0]    pasos;

    modport master (
        output start, con_signo, a, b,
        input  ready, done, lt, eq, gt, pasos
    );

    modport slave (
        input  start, con_signo, a, b,
        output ready, done, lt, eq, gt, pasos
    );

endinterface

// File: rtl/comparador_digito.sv
// -----------------------------------------------------------------------------
// comparador_digito
// Combinational unsigned compare of one DIGIT-bit slice.
//   a, b  : slice operands
//   menor : a < b
//   mayor : a > b
// -----------------------------------------------------------------------------
module comparador_digito #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             menor,
    output logic             mayor
);

    always_comb begin
        menor = (a < b);
        mayor = (a > b);
    end

endmodule

// File: rtl/comparador_serial.sv
// -----------------------------------------------------------------------------
// comparador_serial
// Sequential magnitude comparator: compares two WIDTH-bit operands one
// DIGIT-bit slice per clock, MSB slice first, stopping at the first
// differing slice. Unsigned or two's-complement mode.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of comparador_serial_if
//              (start, con_signo, a, b -> ready, done, lt, eq, gt, pasos)
// -----------------------------------------------------------------------------
module comparador_serial
    import comparador_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    comparador_serial_if.slave bus
);

    localparam int unsigned NDIG = ndig(WIDTH, DIGIT);
    localparam int unsigned PW   = $clog2(NDIG + 1);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, r_b, w_a_nxt, w_b_nxt;
    logic [PW-1:0]    r_idx, w_idx_nxt;
    logic [PW-1:0]    r_pasos, w_pasos_nxt;
    logic [2:0]       r_res, w_res_nxt;
    logic             r_done, w_done_nxt;
    logic             w_menor, w_mayor;
    logic [WIDTH-1:0] w_signo;

    // Flipping the sign bit maps two's-complement order onto unsigned order
    assign w_signo = {bus.con_signo, {(WIDTH-1){1'b0}}};

    comparador_digito #(.DIGIT(DIGIT)) u_digito (
        .a     (r_a[WIDTH-1 -: DIGIT]),
        .b     (r_b[WIDTH-1 -: DIGIT]),
        .menor (w_menor),
        .mayor (w_mayor)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_pasos <= '0;
            r_res   <= RES_NONE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_idx   <= w_idx_nxt;
            r_pasos <= w_pasos_nxt;
            r_res   <= w_res_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_idx_nxt   = r_idx;
        w_pasos_nxt = r_pasos;
        w_res_nxt   = r_res;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_a_nxt     = bus.a ^ w_signo;
                    w_b_nxt     = bus.b ^ w_signo;
                    w_idx_nxt   = '0;
                    w_res_nxt   = RES_NONE;
                    w_state_nxt = CMP;
                end
            end
            CMP: begin
                if (w_menor || w_mayor) begin
                    w_res_nxt   = w_menor ? RES_LT : RES_GT;
                    w_pasos_nxt = r_idx + PW'(1);
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_idx == PW'(NDIG - 1)) begin
                    w_res_nxt   = RES_EQ;
                    w_pasos_nxt = r_idx + PW'(1);
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    // Next slice moves into the top DIGIT bits
                    w_a_nxt   = r_a << DIGIT;
                    w_b_nxt   = r_b << DIGIT;
                    w_idx_nxt = r_idx + PW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.ready = (r_state == IDLE);
    assign bus.done  = r_done;
    assign bus.lt    = r_res[2];
    assign bus.eq    = r_res[1];
    assign bus.gt    = r_res[0];
    assign bus.pasos = r_pasos;

endmodule

// File: tb/tb_comparador_serial.sv
// -----------------------------------------------------------------------------
// tb_comparador_serial
// Four WIDTH=8 comparators (DIGIT 1/2/4/8) share one stimulus set; a
// WIDTH=16/DIGIT=4 comparator has its own. Directed scenarios watch the
// DIGIT=1 and 16-bit instances; the random sweep scoreboards all four 8-bit
// instances.
// -----------------------------------------------------------------------------
module tb_comparador_serial;

    typedef struct {
        logic lt;
        logic eq;
        logic gt;
        int   pasos;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       tb_start = 1'b0;
    logic       tb_sg    = 1'b0;
    logic [7:0] tb_a     = '0;
    logic [7:0] tb_b     = '0;

    logic        s16_start = 1'b0;
    logic        s16_sg    = 1'b0;
    logic [15:0] s16_a     = '0;
    logic [15:0] s16_b     = '0;

    int checks = 0;
    int errors = 0;

    exp_t sb [4][$];
    int   digs [4] = '{1, 2, 4, 8};

    always #5 clk = ~clk;

    comparador_serial_if #(.WIDTH(8),  .DIGIT(1)) if8_1 ();
    comparador_serial_if #(.WIDTH(8),  .DIGIT(2)) if8_2 ();
    comparador_serial_if #(.WIDTH(8),  .DIGIT(4)) if8_4 ();
    comparador_serial_if #(.WIDTH(8),  .DIGIT(8)) if8_8 ();
    comparador_serial_if #(.WIDTH(16), .DIGIT(4)) if16  ();

    assign if8_1.start = tb_start; assign if8_1.con_signo = tb_sg; assign if8_1.a = tb_a; assign if8_1.b = tb_b;
    assign if8_2.start = tb_start; assign if8_2.con_signo = tb_sg; assign if8_2.a = tb_a; assign if8_2.b = tb_b;
    assign if8_4.start = tb_start; assign if8_4.con_signo = tb_sg; assign if8_4.a = tb_a; assign if8_4.b = tb_b;
    assign if8_8.start = tb_start; assign if8_8.con_signo = tb_sg; assign if8_8.a = tb_a; assign if8_8.b = tb_b;
    assign if16.start  = s16_start; assign if16.con_signo = s16_sg; assign if16.a = s16_a; assign if16.b = s16_b;

    comparador_serial #(.WIDTH(8),  .DIGIT(1)) u8_1  (.clk(clk), .rst(rst), .bus(if8_1));
    comparador_serial #(.WIDTH(8),  .DIGIT(2)) u8_2  (.clk(clk), .rst(rst), .bus(if8_2));
    comparador_serial #(.WIDTH(8),  .DIGIT(4)) u8_4  (.clk(clk), .rst(rst), .bus(if8_4));
    comparador_serial #(.WIDTH(8),  .DIGIT(8)) u8_8  (.clk(clk), .rst(rst), .bus(if8_8));
    comparador_serial #(.WIDTH(16), .DIGIT(4)) u16_4 (.clk(clk), .rst(rst), .bus(if16));

    logic [3:0] w_ready, w_done, w_lt, w_eq, w_gt;
    logic [3:0] w_pasos [4];
    assign w_ready = {if8_8.ready, if8_4.ready, if8_2.ready, if8_1.ready};
    assign w_done  = {if8_8.done,  if8_4.done,  if8_2.done,  if8_1.done};
    assign w_lt    = {if8_8.lt,    if8_4.lt,    if8_2.lt,    if8_1.lt};
    assign w_eq    = {if8_8.eq,    if8_4.eq,    if8_2.eq,    if8_1.eq};
    assign w_gt    = {if8_8.gt,    if8_4.gt,    if8_2.gt,    if8_1.gt};
    assign w_pasos[0] = 4'(if8_1.pasos);
    assign w_pasos[1] = 4'(if8_2.pasos);
    assign w_pasos[2] = 4'(if8_4.pasos);
    assign w_pasos[3] = 4'(if8_8.pasos);

    // Reference compare: sign-adjusted magnitude plus first differing slice
    function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b,
                                    input logic sg, input int d);
        exp_t e;
        int   ia, ib, nd, sa, sbv;
        bit   found;
        ia = int'(a) ^ (sg ? 128 : 0);
        ib = int'(b) ^ (sg ? 128 : 0);
        e.lt = (ia < ib);
        e.eq = (ia == ib);
        e.gt = (ia > ib);
        nd = 8 / d;
        e.pasos = nd;
        found = 1'b0;
        for (int i = 0; i < nd; i++) begin
            sa  = (ia >> (8 - d * (i + 1))) & ((1 << d) - 1);
            sbv = (ib >> (8 - d * (i + 1))) & ((1 << d) - 1);
            if (!found && sa != sbv) begin
                e.pasos = i + 1;
                found   = 1'b1;
            end
        end
        return e;
    endfunction

    // Pulses start on the 8-bit group; returns the cycle (relative to the
    // start cycle) in which the DIGIT=1 instance signals done, 0 on timeout.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sg,
                        output int cyc, output logic rdy_c1);
        @(negedge clk);
        tb_a = a; tb_b = b; tb_sg = sg; tb_start = 1'b1;
        cyc = 0;
        rdy_c1 = 1'bx;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) begin
                tb_start = 1'b0;
                rdy_c1 = if8_1.ready;
            end
            if (if8_1.done === 1'b1) begin
                cyc = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (w_ready !== 4'hF || w_done !== 4'h0 || w_lt !== 4'h0 || w_eq !== 4'h0 || w_gt !== 4'h0) begin
            errors++;
            $display("FAIL reset_flags: ready=%b done=%b lt=%b eq=%b gt=%b, required ready=1111 others 0000",
                     w_ready, w_done, w_lt, w_eq, w_gt);
        end
        checks++;
        if (if8_1.pasos !== 4'd0 || if16.pasos !== 3'd0 || if16.ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_pasos: pasos8=%0d pasos16=%0d ready16=%b, required 0 0 1",
                     if8_1.pasos, if16.pasos, if16.ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        int cyc; logic r1;
        run8(8'h35, 8'h37, 1'b0, cyc, r1);
        checks++;
        if (r1 !== 1'b0) begin
            errors++; $display("FAIL unsigned_ready_c1: ready=%b required 0", r1);
        end
        checks++;
        if (cyc !== 8 || {if8_1.lt, if8_1.eq, if8_1.gt} !== 3'b100 || if8_1.pasos !== 4'd7) begin
            errors++;
            $display("FAIL unsigned_35_37: cycle=%0d lt/eq/gt=%b pasos=%0d, required 8 100 7",
                     cyc, {if8_1.lt, if8_1.eq, if8_1.gt}, if8_1.pasos);
        end
        checks++;
        if (if8_1.ready !== 1'b1) begin
            errors++; $display("FAIL unsigned_ready_done: ready=%b required 1", if8_1.ready);
        end
        @(negedge clk);
        checks++;
        if (if8_1.done !== 1'b0 || if8_1.lt !== 1'b1 || if8_1.pasos !== 4'd7) begin
            errors++;
            $display("FAIL unsigned_hold: done=%b lt=%b pasos=%0d, required 0 1 7",
                     if8_1.done, if8_1.lt, if8_1.pasos);
        end
    endtask

    task automatic test_signed();
        int cyc; logic r1;
        run8(8'hFF, 8'h01, 1'b1, cyc, r1);
        checks++;
        if (cyc !== 2 || {if8_1.lt, if8_1.eq, if8_1.gt} !== 3'b100 || if8_1.pasos !== 4'd1) begin
            errors++;
            $display("FAIL signed_m1_1: cycle=%0d lt/eq/gt=%b pasos=%0d, required 2 100 1",
                     cyc, {if8_1.lt, if8_1.eq, if8_1.gt}, if8_1.pasos);
        end
        run8(8'hFF, 8'h01, 1'b0, cyc, r1);
        checks++;
        if (cyc !== 2 || {if8_1.lt, if8_1.eq, if8_1.gt} !== 3'b001 || if8_1.pasos !== 4'd1) begin
            errors++;
            $display("FAIL unsigned_ff_01: cycle=%0d lt/eq/gt=%b pasos=%0d, required 2 001 1",
                     cyc, {if8_1.lt, if8_1.eq, if8_1.gt}, if8_1.pasos);
        end
    endtask

    task automatic test_back_to_back();
        int  cyc1 = 0, cyc2 = 0;
        logic [2:0] res1 = 'x;
        logic [2:0] p1 = 'x;
        @(negedge clk);
        s16_a = 16'hBEEF; s16_b = 16'hBEEF; s16_sg = 1'b0; s16_start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) s16_start = 1'b0;
            if (if16.done === 1'b1) begin
                cyc1 = n;
                res1 = {if16.lt, if16.eq, if16.gt};
                p1   = if16.pasos;
                // New request issued in the done cycle itself
                s16_a = 16'h0000; s16_b = 16'h8000; s16_sg = 1'b1; s16_start = 1'b1;
                break;
            end
        end
        checks++;
        if (cyc1 !== 5 || res1 !== 3'b010 || p1 !== 3'd4) begin
            errors++;
            $display("FAIL b2b_first_eq: cycle=%0d lt/eq/gt=%b pasos=%0d, required 5 010 4", cyc1, res1, p1);
        end
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) begin
                s16_start = 1'b0;
                checks++;
                if (if16.ready !== 1'b0 || {if16.lt, if16.eq, if16.gt} !== 3'b000) begin
                    errors++;
                    $display("FAIL b2b_clear: ready=%b lt/eq/gt=%b, required 0 000",
                             if16.ready, {if16.lt, if16.eq, if16.gt});
                end
            end
            if (if16.done === 1'b1) begin
                cyc2 = n;
                break;
            end
        end
        checks++;
        if (cyc2 !== 2 || {if16.lt, if16.eq, if16.gt} !== 3'b001 || if16.pasos !== 3'd1) begin
            errors++;
            $display("FAIL b2b_second_signed: cycle=%0d lt/eq/gt=%b pasos=%0d, required 2 001 1",
                     cyc2, {if16.lt, if16.eq, if16.gt}, if16.pasos);
        end
    endtask

    task automatic test_ignored_start();
        int ndone = 0, first = 0;
        @(negedge clk);
        tb_a = 8'h35; tb_b = 8'h37; tb_sg = 1'b0; tb_start = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n == 1) tb_start = 1'b0;
            if (n == 3) begin tb_a = 8'h80; tb_b = 8'h00; tb_start = 1'b1; end
            if (n == 4) tb_start = 1'b0;
            if (if8_1.done === 1'b1) begin
                ndone++;
                if (first == 0) first = n;
            end
        end
        checks++;
        if (ndone !== 1 || first !== 8 || {if8_1.lt, if8_1.eq, if8_1.gt} !== 3'b100 || if8_1.pasos !== 4'd7) begin
            errors++;
            $display("FAIL ignored_start: dones=%0d first=%0d lt/eq/gt=%b pasos=%0d, required 1 8 100 7",
                     ndone, first, {if8_1.lt, if8_1.eq, if8_1.gt}, if8_1.pasos);
        end
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        @(negedge clk);
        tb_a = 8'h35; tb_b = 8'h37; tb_sg = 1'b0; tb_start = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n == 1) tb_start = 1'b0;
            if (n == 3) rst = 1'b1;
            if (n == 4) begin
                rst = 1'b0;
                checks++;
                if (if8_1.ready !== 1'b1 || if8_1.done !== 1'b0 ||
                    {if8_1.lt, if8_1.eq, if8_1.gt} !== 3'b000 || if8_1.pasos !== 4'd0) begin
                    errors++;
                    $display("FAIL reset_mid: ready=%b done=%b lt/eq/gt=%b pasos=%0d, required 1 0 000 0",
                             if8_1.ready, if8_1.done, {if8_1.lt, if8_1.eq, if8_1.gt}, if8_1.pasos);
                end
            end
            if (n > 4 && if8_1.done === 1'b1) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++; $display("FAIL reset_mid_no_done: dones=%0d required 0", ndone);
        end
        // rst and start together: rst wins
        @(negedge clk);
        rst = 1'b1; tb_start = 1'b1; tb_a = 8'h00; tb_b = 8'hFF;
        @(negedge clk);
        rst = 1'b0; tb_start = 1'b0;
        checks++;
        if (if8_1.ready !== 1'b1 || {if8_1.lt, if8_1.eq, if8_1.gt} !== 3'b000) begin
            errors++;
            $display("FAIL rst_beats_start: ready=%b lt/eq/gt=%b, required 1 000",
                     if8_1.ready, {if8_1.lt, if8_1.eq, if8_1.gt});
        end
    endtask

    task automatic test_random_sweep();
        exp_t e;
        logic [7:0] a, b;
        logic sg;
        bit   all_empty;
        for (int it = 0; it < 60; it++) begin
            for (int w = 0; w < 20 && w_ready !== 4'hF; w++) @(negedge clk);
            if (w_ready !== 4'hF) begin
                checks++; errors++;
                $display("FAIL sweep_ready_timeout: ready=%b required 1111", w_ready);
            end
            a  = 8'($urandom);
            b  = (it % 4 == 0) ? a : 8'($urandom);
            if (it % 7 == 3) b = a ^ 8'($urandom_range(0, 3));
            sg = 1'(it & 1);
            @(negedge clk);
            tb_a = a; tb_b = b; tb_sg = sg; tb_start = 1'b1;
            for (int i = 0; i < 4; i++) sb[i].push_back(model8(a, b, sg, digs[i]));
            for (int n = 1; n <= 15; n++) begin
                @(negedge clk);
                if (n == 1) tb_start = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (w_done[i] === 1'b1) begin
                        checks++;
                        if (sb[i].size() == 0) begin
                            errors++;
                            $display("FAIL sweep_extra_done: digit=%0d unexpected done", digs[i]);
                        end else begin
                            e = sb[i].pop_front();
                            if ({w_lt[i], w_eq[i], w_gt[i]} !== {e.lt, e.eq, e.gt} ||
                                w_pasos[i] !== 4'(e.pasos) || $countones({w_lt[i], w_eq[i], w_gt[i]}) != 1) begin
                                errors++;
                                $display("FAIL sweep_result: digit=%0d a=%h b=%h sg=%b lt/eq/gt=%b pasos=%0d, required %b %0d",
                                         digs[i], a, b, sg, {w_lt[i], w_eq[i], w_gt[i]}, w_pasos[i],
                                         {e.lt, e.eq, e.gt}, e.pasos);
                            end
                        end
                    end
                end
                all_empty = 1'b1;
                for (int i = 0; i < 4; i++) if (sb[i].size() != 0) all_empty = 1'b0;
                if (all_empty) break;
            end
            for (int i = 0; i < 4; i++) begin
                if (sb[i].size() != 0) begin
                    checks++; errors++;
                    $display("FAIL sweep_done_timeout: digit=%0d pending=%0d", digs[i], sb[i].size());
                    sb[i].delete();
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_ignored_start();
        repeat (12) @(negedge clk);
        test_reset_mid();
        repeat (12) @(negedge clk);
        test_random_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
